// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the PLL dynamic phase-shift sequencer.
// Imported by pll_phase_stepper and its testbench.
package pll_phase_pkg;

    localparam int CNTSEL_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_LO,
        WAIT_HI,
        GAP,
        FINISH
    } state_t;

    localparam logic [CNTSEL_W-1:0] CNT_ALL = 5'b00000;
    localparam logic [CNTSEL_W-1:0] CNT_M   = 5'b00001;
    localparam logic [CNTSEL_W-1:0] CNT_C0  = 5'b00010;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser with a configurable reset value.
// Used to bring the PLL phase_done strobe into the clk domain.
module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_phase_stepper.sv
// Issues N signed phase steps to a PLL dynamic phase-shift port,
// one handshake at a time, with abort and handshake timeout.
module pll_phase_stepper
    import pll_phase_pkg::*;
#(
    parameter int STEP_W      = 16,
    parameter int CNTSEL_W    = pll_phase_pkg::CNTSEL_W,
    parameter int EN_CYCLES   = 2,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CNTSEL_W-1:0] cmd_cntsel,
    input  logic [STEP_W-1:0]   cmd_steps,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic [STEP_W-1:0]   steps_done,
    output logic                phase_en,
    output logic                updn,
    output logic [CNTSEL_W-1:0] cntsel,
    input  logic                phase_done
);

    localparam int MAX_A   = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX = (TIMEOUT > MAX_A) ? TIMEOUT : MAX_A;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    cnt;
    logic [STEP_W-1:0]   remaining;
    logic [STEP_W-1:0]   steps_abs;
    logic                abort_pend;
    logic                to_q;
    logic                pd_sync;

    logic                accept;
    logic                cnt_clr;
    logic                step_inc;
    logic                to_hit;

    bit_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_pd_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (phase_done),
        .q       (pd_sync)
    );

    // Magnitude of the most negative command still fits as unsigned.
    assign steps_abs = cmd_steps[STEP_W-1] ? (~cmd_steps + STEP_W'(1))
                                           : cmd_steps;

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        cnt_clr  = 1'b0;
        step_inc = 1'b0;
        to_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = (cmd_steps == '0) ? FINISH : PULSE;
                end
            end
            PULSE: begin
                if (cnt == EN_LAST) begin
                    cnt_clr = 1'b1;
                    state_n = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!pd_sync) begin
                    cnt_clr = 1'b1;
                    state_n = WAIT_HI;
                end else if (cnt == TO_LAST) begin
                    to_hit  = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_HI: begin
                if (pd_sync) begin
                    step_inc = 1'b1;
                    cnt_clr  = 1'b1;
                    state_n  = (remaining == STEP_W'(1) || abort_pend)
                               ? FINISH : GAP;
                end else if (cnt == TO_LAST) begin
                    to_hit  = 1'b1;
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_clr = 1'b1;
                    state_n = abort_pend ? FINISH : PULSE;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            remaining  <= '0;
            steps_done <= '0;
            updn       <= 1'b0;
            cntsel     <= '0;
            abort_pend <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            to_q <= to_hit;
            if (cnt_clr || state == IDLE || state == FINISH) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                remaining  <= steps_abs;
                steps_done <= '0;
                updn       <= ~cmd_steps[STEP_W-1];
                cntsel     <= cmd_cntsel;
            end else if (step_inc) begin
                remaining <= remaining - 1'b1;
                if (steps_done != '1) begin
                    steps_done <= steps_done + 1'b1;
                end
            end
            if (accept || state == FINISH) begin
                abort_pend <= 1'b0;
            end else if (state != IDLE && abort) begin
                abort_pend <= 1'b1;
            end
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);
    assign phase_en    = (state == PULSE);
    assign timeout_err = to_q;

endmodule
